// File: rtl/rbm_sched_pkg.sv
// Shared definitions for the RBM Gibbs sampling scheduler, layer engine and host sequencer.
// Holds the state encoding, the pass direction constants and small state helpers.
package rbm_sched_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ENC_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ENC_UP_ISSUE   = 3'd1;
  localparam logic [STATE_W-1:0] ENC_UP_WAIT    = 3'd2;
  localparam logic [STATE_W-1:0] ENC_DOWN_ISSUE = 3'd3;
  localparam logic [STATE_W-1:0] ENC_DOWN_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] ENC_DONE       = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = ENC_IDLE,
    ST_UP_ISSUE   = ENC_UP_ISSUE,
    ST_UP_WAIT    = ENC_UP_WAIT,
    ST_DOWN_ISSUE = ENC_DOWN_ISSUE,
    ST_DOWN_WAIT  = ENC_DOWN_WAIT,
    ST_DONE       = ENC_DONE
  } sched_state_e;

  // Engine pass direction: up is visible->hidden, down is hidden->visible.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic is_issue(input sched_state_e s);
    return (s == ST_UP_ISSUE) || (s == ST_DOWN_ISSUE);
  endfunction

  function automatic logic is_wait(input sched_state_e s);
    return (s == ST_UP_WAIT) || (s == ST_DOWN_WAIT);
  endfunction

endpackage

// File: rtl/rbm_pass_watchdog.sv
// Per-pass watchdog: counts enabled cycles since the last clear and flags the
// last allowed cycle so the scheduler can abandon a stuck engine pass.
module rbm_pass_watchdog #(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(timeout_cycles);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count so a held enable can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the timeout_cycles-th enabled cycle after a clear.
  assign expired_c = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rbm_gibbs_scheduler.sv
// Time-shares one RBM layer engine between up and down passes to run k-step
// Gibbs sampling, returning the final visible and hidden samples to the host.
module rbm_gibbs_scheduler
  import rbm_sched_pkg::*;
#(
  parameter int unsigned visible_dim    = 15,
  parameter int unsigned hidden_dim     = 5,
  parameter int unsigned io_dim         = 15,
  parameter int unsigned step_bits      = 4,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [step_bits-1:0]   num_steps,
  input  logic [visible_dim-1:0] vis_in,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [visible_dim-1:0] vis_out,
  output logic [hidden_dim-1:0]  hid_out,
  output logic                   eng_start,
  output logic                   eng_dir,
  output logic [io_dim-1:0]      eng_in,
  input  logic                   eng_done,
  input  logic [io_dim-1:0]      eng_out
);

  sched_state_e state_q, state_d;

  logic [visible_dim-1:0] v_q, v_d;
  logic [hidden_dim-1:0]  h_q, h_d;
  logic [step_bits-1:0]   k_q, k_d;
  logic [step_bits-1:0]   step_q, step_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [visible_dim-1:0] vis_out_q, vis_out_d;
  logic [hidden_dim-1:0]  hid_out_q, hid_out_d;
  logic                   eng_start_q, eng_start_d;
  logic                   eng_dir_q, eng_dir_d;
  logic [io_dim-1:0]      eng_in_q, eng_in_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired_c;

  // Watchdog restarts for every pass and only runs while waiting on the engine.
  assign wd_clear  = is_issue(state_q) || (state_q == ST_IDLE);
  assign wd_enable = is_wait(state_q);

  rbm_pass_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .expired_c(wd_expired_c)
  );

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    h_d         = h_q;
    k_d         = k_q;
    step_d      = step_q;
    error_d     = error_q;
    vis_out_d   = vis_out_q;
    hid_out_d   = hid_out_q;
    eng_dir_d   = eng_dir_q;
    eng_in_d    = eng_in_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    eng_start_d = 1'b0;

    // Abort outranks engine completion and timeout; partial results are dropped.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            v_d     = vis_in;
            k_d     = num_steps;
            step_d  = '0;
            error_d = 1'b0;
            state_d = ST_UP_ISSUE;
          end
        end
        ST_UP_ISSUE: begin
          state_d = ST_UP_WAIT;
        end
        ST_UP_WAIT: begin
          if (eng_done) begin
            h_d     = eng_out[hidden_dim-1:0];
            state_d = (step_q == k_q) ? ST_DONE : ST_DOWN_ISSUE;
          end else if (wd_expired_c) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DOWN_ISSUE: begin
          state_d = ST_DOWN_WAIT;
        end
        ST_DOWN_WAIT: begin
          if (eng_done) begin
            v_d     = eng_out[visible_dim-1:0];
            step_d  = step_q + step_bits'(1);
            state_d = ST_UP_ISSUE;
          end else if (wd_expired_c) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    eng_start_d = is_issue(state_d);

    if (state_d == ST_UP_ISSUE) begin
      eng_dir_d = DIR_UP;
      eng_in_d  = io_dim'(v_d);
    end
    if (state_d == ST_DOWN_ISSUE) begin
      eng_dir_d = DIR_DOWN;
      eng_in_d  = io_dim'(h_d);
    end
    if (state_d == ST_DONE) begin
      vis_out_d = v_d;
      hid_out_d = h_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      v_q         <= '0;
      h_q         <= '0;
      k_q         <= '0;
      step_q      <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vis_out_q   <= '0;
      hid_out_q   <= '0;
      eng_start_q <= 1'b0;
      eng_dir_q   <= DIR_UP;
      eng_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      h_q         <= h_d;
      k_q         <= k_d;
      step_q      <= step_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vis_out_q   <= vis_out_d;
      hid_out_q   <= hid_out_d;
      eng_start_q <= eng_start_d;
      eng_dir_q   <= eng_dir_d;
      eng_in_q    <= eng_in_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign vis_out   = vis_out_q;
  assign hid_out   = hid_out_q;
  assign eng_start = eng_start_q;
  assign eng_dir   = eng_dir_q;
  assign eng_in    = eng_in_q;

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Self-checking bench for rbm_gibbs_scheduler: a behavioural layer engine with
// programmable latency and a Gibbs-chain reference model built from the same engine maps.
module tb_rbm_gibbs_scheduler;

  localparam int VD  = 15;
  localparam int HD  = 5;
  localparam int IOD = 15;
  localparam int SB  = 4;
  localparam int TMO = 8;

  logic           clock, reset, start, abort;
  logic [SB-1:0]  num_steps;
  logic [VD-1:0]  vis_in, vis_out;
  logic [HD-1:0]  hid_out;
  logic           busy, done, error, eng_start, eng_dir, eng_done;
  logic [IOD-1:0] eng_in, eng_out;

  rbm_gibbs_scheduler #(
    .visible_dim(VD), .hidden_dim(HD), .io_dim(IOD), .step_bits(SB), .timeout_cycles(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_steps(num_steps), .vis_in(vis_in),
    .abort(abort), .busy(busy), .done(done), .error(error), .vis_out(vis_out),
    .hid_out(hid_out), .eng_start(eng_start), .eng_dir(eng_dir), .eng_in(eng_in),
    .eng_done(eng_done), .eng_out(eng_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          eng_lat = 3;
  bit          eng_mute = 1'b0;
  int          spur_cnt = 0;
  logic [31:0] eng_salt = 32'h0;
  logic [VD-1:0] last_v = '0;
  logic [HD-1:0] last_h = '0;

  int             spur_seen = 0;
  int             eng_cnt = 0;
  int             eng_glitch = 0;
  logic           p_dir = 1'b0;
  logic [IOD-1:0] p_in = '0;
  logic           log_dir[$];
  logic [IOD-1:0] log_in[$];

  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] s);
    logic [31:0] y;
    y = (x ^ s) * 32'h9E3779B1;
    y = y ^ (y >> 15);
    y = y * 32'h85EBCA6B;
    y = y ^ (y >> 13);
    return y;
  endfunction

  // Engine transfer maps: a fixed pseudo-random sampled response per input vector.
  function automatic logic [HD-1:0] f_up(input logic [VD-1:0] v);
    logic [31:0] r;
    r = mix(32'(v), eng_salt);
    return r[HD-1:0];
  endfunction

  function automatic logic [VD-1:0] f_down(input logic [HD-1:0] h);
    logic [31:0] r;
    r = mix(32'(h), eng_salt ^ 32'h5A5AC3C3);
    return r[VD-1:0];
  endfunction

  function automatic logic [IOD-1:0] eng_resp(input logic dir, input logic [IOD-1:0] x);
    logic [IOD-1:0] r;
    if (dir == 1'b0) begin
      r = IOD'($urandom);
      r[HD-1:0] = f_up(x[VD-1:0]);
    end else begin
      r = IOD'(f_down(x[HD-1:0]));
    end
    return r;
  endfunction

  // k-step Gibbs chain: h0=up(v0), then k rounds of v=down(h), h=up(v).
  task automatic ref_gibbs(input logic [VD-1:0] v0, input int k,
                           output logic [VD-1:0] v, output logic [HD-1:0] h);
    v = v0;
    h = f_up(v0);
    for (int i = 0; i < k; i++) begin
      v = f_down(h);
      h = f_up(v);
    end
  endtask

  // Layer engine model: answers each eng_start after eng_lat cycles.
  initial begin
    eng_done = 1'b0;
    eng_out  = '0;
    forever begin
      @(posedge clock);
      #1;
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        if (eng_dir !== p_dir) eng_glitch++;
        eng_cnt--;
        if (eng_cnt == 0 && !eng_mute) begin
          eng_done = 1'b1;
          eng_out  = eng_resp(p_dir, p_in);
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        eng_done  = 1'b1;
        eng_out   = IOD'($urandom);
      end
      if (eng_start === 1'b1) begin
        p_dir = eng_dir;
        p_in  = eng_in;
        log_dir.push_back(eng_dir);
        log_in.push_back(eng_in);
        eng_cnt = eng_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},      32'(busy), 32'd0);
    chk({tag, " done"},      32'(done), 32'd0);
    chk({tag, " error"},     32'(error), 32'd0);
    chk({tag, " eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, " eng_dir"},   32'(eng_dir), 32'd0);
    chk({tag, " eng_in"},    32'(eng_in), 32'd0);
    chk({tag, " vis_out"},   32'(vis_out), 32'd0);
    chk({tag, " hid_out"},   32'(hid_out), 32'd0);
  endtask

  // One complete job; noise adds a spurious eng_done in UP_ISSUE and start pulses while busy/in DONE.
  task automatic run_job(input logic [VD-1:0] v0, input int k, input int lat,
                         input int exp_cyc, input bit noise, input string tag);
    logic [VD-1:0] ev, mv;
    logic [HD-1:0] eh, mh;
    int rd0, g0, cyc, npass;
    ref_gibbs(v0, k, ev, eh);
    eng_lat  = lat;
    eng_mute = 1'b0;
    rd0 = log_dir.size();
    g0  = eng_glitch;
    start = 1'b1; num_steps = SB'(k); vis_in = v0;
    if (noise) begin
      #2;
      spur_cnt++;
    end
    tick();
    cyc = 1;
    start = 1'b0; num_steps = SB'($urandom); vis_in = VD'($urandom);
    chk({tag, " busy_c1"}, 32'(busy), 32'd1);
    chk({tag, " eng_start_c1"}, 32'(eng_start), 32'd1);
    while (done !== 1'b1 && cyc < exp_cyc + 20) begin
      start = noise && (cyc == 3);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " error"}, 32'(error), 32'd0);
    chk({tag, " vis_out"}, 32'(vis_out), 32'(ev));
    chk({tag, " hid_out"}, 32'(hid_out), 32'(eh));
    npass = log_dir.size() - rd0;
    chk({tag, " pass_count"}, 32'(npass), 32'(2 * k + 1));
    mv = v0;
    mh = '0;
    for (int i = 0; i < npass && i < 2 * k + 1; i++) begin
      if (i % 2 == 0) begin
        chk({tag, " pass_dir"}, 32'(log_dir[rd0 + i]), 32'd0);
        chk({tag, " pass_in"}, 32'(log_in[rd0 + i]), 32'(mv));
        mh = f_up(mv);
      end else begin
        chk({tag, " pass_dir"}, 32'(log_dir[rd0 + i]), 32'd1);
        chk({tag, " pass_in"}, 32'(log_in[rd0 + i]), 32'(mh));
        mv = f_down(mh);
      end
    end
    chk({tag, " dir_stable"}, 32'(eng_glitch - g0), 32'd0);
    if (noise) begin
      start = 1'b1; num_steps = SB'($urandom); vis_in = VD'($urandom);
    end
    tick();
    start = 1'b0;
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_after"}, 32'(done), 32'd0);
    last_v = ev;
    last_h = eh;
  endtask

  typedef struct {
    logic [VD-1:0] v0;
    int            k;
    int            lat;
    int            exp_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc, rd0;
    logic [VD-1:0] v0;

    tbl[0] = '{v0: 15'h1234, k: 0,  lat: 3, exp_cyc: 5};
    tbl[1] = '{v0: 15'h4ACE, k: 2,  lat: 3, exp_cyc: 21};
    tbl[2] = '{v0: 15'h7FFF, k: 1,  lat: 1, exp_cyc: 7};
    tbl[3] = '{v0: 15'h0001, k: 3,  lat: 2, exp_cyc: 22};
    tbl[4] = '{v0: 15'h5555, k: 1,  lat: 8, exp_cyc: 28};
    tbl[5] = '{v0: 15'h2B3C, k: 15, lat: 1, exp_cyc: 63};

    eng_salt = $urandom;
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0; vis_in = '0;
    tick();
    tick();
    chk_all_zero("reset");
    #3 reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_job(tbl[i].v0, tbl[i].k, tbl[i].lat, tbl[i].exp_cyc, 1'b0, "table");
    end

    // Engine never answers: timeout after TMO wait cycles with partial results.
    eng_mute = 1'b1;
    eng_lat  = 3;
    rd0 = log_dir.size();
    v0  = 15'h0F0F;
    start = 1'b1; num_steps = 4'd3; vis_in = v0;
    tick();
    cyc = 1;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("timeout done_cycle", 32'(cyc), 32'd10);
    chk("timeout busy", 32'(busy), 32'd1);
    chk("timeout error", 32'(error), 32'd1);
    chk("timeout vis_out", 32'(vis_out), 32'(v0));
    chk("timeout hid_out", 32'(hid_out), 32'(last_h));
    chk("timeout pass_count", 32'(log_dir.size() - rd0), 32'd1);
    tick();
    chk("timeout busy_after", 32'(busy), 32'd0);
    eng_mute = 1'b0;
    last_v = v0;

    // Abort in the first DOWN_WAIT (cycle 6 for L=3).
    eng_lat = 3;
    start = 1'b1; num_steps = 4'd2; vis_in = 15'h3C3C;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort dir_down", 32'(eng_dir), 32'd1);
    chk("abort busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort eng_start", 32'(eng_start), 32'd0);
    chk("abort vis_out", 32'(vis_out), 32'(last_v));
    chk("abort hid_out", 32'(hid_out), 32'(last_h));
    tick();
    chk("abort busy_late", 32'(busy), 32'd0);
    chk("abort done_late", 32'(done), 32'd0);
    run_job(15'h6A5F, 1, 3, 13, 1'b0, "post_abort");

    run_job(15'h1357, 2, 3, 21, 1'b1, "noise");

    for (int i = 0; i < 20; i++) begin
      int k, l;
      k = (i < 15) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 15));
      l = int'($urandom_range(1, 8));
      run_job(VD'($urandom), k, l, 1 + (2 * k + 1) * (l + 1), bit'(i % 4 == 3), "rnd");
    end

    // Asynchronous reset in mid UP_WAIT; the engine's late eng_done must be ignored.
    eng_lat = 3;
    start = 1'b1; num_steps = 4'd1; vis_in = 15'h0ABC;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rst_mid busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    #1 reset = 1'b0;
    tick();
    chk("rst_mid spur busy", 32'(busy), 32'd0);
    tick();
    chk("rst_mid idle busy", 32'(busy), 32'd0);
    chk("rst_mid idle done", 32'(done), 32'd0);
    chk("rst_mid idle eng_start", 32'(eng_start), 32'd0);
    chk("rst_mid idle hid_out", 32'(hid_out), 32'd0);
    run_job(15'h7123, 3, 2, 22, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rbm_gibbs_scheduler.md
# rbm_gibbs_scheduler

Sequencing controller that time-shares a single RBM layer engine between the visible-to-hidden (up) and hidden-to-visible (down) passes needed for k-step Gibbs sampling. It accepts a binary visible vector and a step count from the host. It issues alternating engine passes, latches each sampled vector, and returns the final visible and hidden samples. It sits between the training/inference host logic and the layer datapath, which performs the weighted sum, sigmoid and stochastic sampling.

## Interface
Parameters:
- visible_dim, 15: number of visible units.
- hidden_dim, 5: number of hidden units.
- io_dim, 15: engine vector width; must equal max(visible_dim, hidden_dim).
- step_bits, 4: width of the Gibbs step count.
- timeout_cycles, 1024: maximum cycles allowed in one engine wait before aborting with error.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only in IDLE.
- num_steps  in  step_bits  Gibbs steps k, latched on accepted start.
- vis_in  in  visible_dim  initial visible sample v0, latched on accepted start.
- abort  in  1  synchronous cancel of a running job.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- done  out  1  one-cycle pulse in the DONE state.
- error  out  1  valid with done; 1 if a pass timed out.
- vis_out  out  visible_dim  final visible sample v_k.
- hid_out  out  hidden_dim  final hidden sample h_k.
- eng_start  out  1  one-cycle pass request to the engine.
- eng_dir  out  1  0 = up (v→h), 1 = down (h→v); stable from eng_start until eng_done.
- eng_in  out  io_dim  pass input, zero-extended in upper bits.
- eng_done  in  1  engine pass complete; eng_out valid in the same cycle.
- eng_out  in  io_dim  sampled binary output; only the low hidden_dim or visible_dim bits are used.

## Operation
- States: IDLE, UP_ISSUE, UP_WAIT, DOWN_ISSUE, DOWN_WAIT, DONE.
- IDLE: when start=1, latch vis_in into v_reg, num_steps into k_reg, clear step_cnt and error, then go to UP_ISSUE.
- UP_ISSUE: eng_start=1, eng_dir=0, eng_in=v_reg; next state is UP_WAIT.
- UP_WAIT: on eng_done, h_reg ← eng_out[hidden_dim-1:0]. If step_cnt==k_reg go to DONE, else go to DOWN_ISSUE.
- DOWN_ISSUE: eng_start=1, eng_dir=1, eng_in=h_reg; next state is DOWN_WAIT.
- DOWN_WAIT: on eng_done, v_reg ← eng_out[visible_dim-1:0], step_cnt+1, then go to UP_ISSUE.
- A job of k steps runs k+1 up passes and k down passes. k=0 runs one up pass only.
- DONE: done=1, vis_out=v_reg, hid_out=h_reg; next state is IDLE.
- vis_out and hid_out update only in DONE and hold until the next DONE or reset.
- Timeout: the watchdog counts cycles in either WAIT state. When it reaches timeout_cycles without eng_done, go to DONE with error=1; vis_out and hid_out take the partial v_reg and h_reg.
- abort=1 in any non-IDLE state returns to IDLE next cycle. There is no done pulse, vis_out and hid_out are unchanged, and eng_start is suppressed in that cycle. abort has priority over eng_done and timeout.
- eng_done outside a WAIT state is ignored.
- start while busy is ignored.
- step_cnt is step_bits wide and never wraps, because k_reg is at most 2^step_bits−1.

## Timing
- Reset values: busy=0, done=0, error=0, eng_start=0, eng_dir=0, eng_in=0, vis_out=0, hid_out=0, state IDLE.
- An assertion of reset mid-job forces these values immediately; the engine is not notified.
- start is sampled at cycle 0; eng_start for the first pass is at cycle 1.
- eng_done is sampled only in WAIT states. The earliest legal eng_done is one cycle after eng_start, so engine latency L ≥ 1.
- Each pass takes L+1 cycles. done is asserted at cycle 1+(2k+1)(L+1), and the next start is accepted the cycle after done.
- eng_start and done are registered outputs.

## Structure
- Shared package rbm_sched_pkg holds the state encoding localparams and the DIR_UP=0 / DIR_DOWN=1 constants, for reuse by the layer engine and the host sequencer.
- One sub-module, rbm_pass_watchdog: a clearable counter of clog2(timeout_cycles+1) bits with enable and expired outputs. It clears on each ISSUE state.

## Test plan
- Set visible_dim=15, hidden_dim=5, engine model with L=3. Drive start with num_steps=0 and vis_in=15'h1234. Expect one eng_start with eng_dir=0 and eng_in=15'h1234. Expect done at cycle 5 with hid_out equal to the model output and vis_out=15'h1234.
- Drive num_steps=2 with L=3. Expect eng_dir sequence 0,1,0,1,0 and done at cycle 21. vis_out must equal the second down output and hid_out the third up output.
- Engine never asserts eng_done, timeout_cycles=8. Expect done with error=1 at cycle 10 and busy low at cycle 11.
- Assert abort during the first DOWN_WAIT. Expect state IDLE next cycle, no done, outputs unchanged. A new start two cycles later runs normally.
- Assert reset asynchronously mid-UP_WAIT. Expect all outputs 0 immediately. A spurious eng_done after reset is ignored.
- Pulse start during busy, and pulse eng_done during UP_ISSUE. Neither may alter the pass sequence or results.
